// File: rtl/mult_cell_arbiter.sv
// Round-robin sharing of one 2-stage 32x32->64 multiplier cell among NUM_REQ requesters.
// Tracks which requester owns each pipeline stage and returns results in accept order.
`timescale 1ns/1ps

module mult_cell_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_src1,
    input  logic [32*NUM_REQ-1:0]   req_src2,
    input  logic [NUM_REQ-1:0]      req_src1_signed,
    input  logic [NUM_REQ-1:0]      req_src2_signed,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [63:0]             rsp_result,
    output logic [31:0]             mul_src1,
    output logic [31:0]             mul_src2,
    output logic                    mul_src1_signed,
    output logic                    mul_src2_signed,
    output logic                    mul_en0,
    output logic                    mul_en1,
    input  logic [63:0]             mul_result
);

    logic              r_s1_valid;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s2_valid;
    logic [ID_W-1:0]   r_s2_id;
    logic [ID_W-1:0]   r_rr_ptr;

    logic [NUM_REQ-1:0] w_s2_onehot;
    logic               w_s2_take;
    logic               w_s2_free;
    logic               w_s1_free;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_found;
    logic [ID_W-1:0]    w_rr_next;

    always_comb begin
        w_s2_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_s2_valid && (r_s2_id == ID_W'(i))) begin
                w_s2_onehot[i] = 1'b1;
            end
        end
    end

    assign w_s2_take = r_s2_valid & (|(rsp_ready & w_s2_onehot));
    assign w_s2_free = ~r_s2_valid | w_s2_take;
    assign mul_en1   = r_s1_valid & w_s2_free;
    assign w_s1_free = ~r_s1_valid | mul_en1;

    // Two passes implement the circular search starting at r_rr_ptr without a variable rotate;
    // gating with reset_n keeps req_ready low while reset is held.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        if (w_s1_free && reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_grant_id = ID_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] && (ID_W'(i) < r_rr_ptr)) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_grant_id = ID_W'(i);
                end
            end
        end
    end

    assign req_ready = w_grant;
    assign mul_en0   = w_found;
    assign w_rr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

    always_comb begin
        mul_src1        = '0;
        mul_src2        = '0;
        mul_src1_signed = 1'b0;
        mul_src2_signed = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                mul_src1        = req_src1[32*i +: 32];
                mul_src2        = req_src2[32*i +: 32];
                mul_src1_signed = req_src1_signed[i];
                mul_src2_signed = req_src2_signed[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_found) begin
                r_rr_ptr   <= w_rr_next;
                r_s1_valid <= 1'b1;
                r_s1_id    <= w_grant_id;
            end else if (mul_en1) begin
                r_s1_valid <= 1'b0;
            end
            if (mul_en1) begin
                r_s2_valid <= 1'b1;
                r_s2_id    <= r_s1_id;
            end else if (w_s2_take) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid  = w_s2_onehot;
    assign rsp_result = r_s2_valid ? mul_result : 64'd0;

endmodule
